// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - control-word layout, bubble constant and flag helpers for ctrl_pipe_unit
package ctrl_pipe_pkg;

  localparam int CW_W        = 7;
  localparam int CW_REGWRITE = 0;
  localparam int CW_ALUSRC   = 1;
  localparam int CW_MEMREAD  = 2;
  localparam int CW_MEMWRITE = 3;
  localparam int CW_MEM2REG  = 4;
  localparam int CW_BRANCH   = 5;
  localparam int CW_JUMP     = 6;

  typedef logic [CW_W-1:0] ctrl_word_t;

  localparam ctrl_word_t CW_BUBBLE = '0;

  // Instruction-type flags gathered in one vector so they can be counted.
  typedef struct packed {
    logic branch;
    logic jump;
    logic lw;
    logic itype;
    logic rtype;
    logic stype;
  } type_flags_t;

  function automatic logic multi_flag(input type_flags_t f);
    logic [2:0] n;
    n = {2'b00, f.stype} + {2'b00, f.rtype} + {2'b00, f.itype}
      + {2'b00, f.lw}    + {2'b00, f.jump}  + {2'b00, f.branch};
    return (n > 3'd1);
  endfunction

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// rtl/ctrl_pipe_unit_decode.sv - combinational flags-to-control-word decoder (module ctrl_decode)
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic                  is_stype,
  input  logic                  is_rtype,
  input  logic                  is_itype,
  input  logic                  is_lw,
  input  logic                  is_jump,
  input  logic                  is_branch,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output ctrl_word_t            cw,
  output logic                  bubble,
  output logic                  illegal
);

  type_flags_t flags;
  ctrl_word_t  raw;
  logic        multi;

  always_comb begin
    flags        = '0;
    flags.stype  = is_stype;
    flags.rtype  = is_rtype;
    flags.itype  = is_itype;
    flags.lw     = is_lw;
    flags.jump   = is_jump;
    flags.branch = is_branch;
    multi        = multi_flag(flags);
  end

  always_comb begin
    raw              = CW_BUBBLE;
    raw[CW_REGWRITE] = ~(is_stype | is_branch) & (id_rd != '0);
    raw[CW_ALUSRC]   = ~(is_rtype | is_branch);
    raw[CW_MEMREAD]  = is_lw;
    raw[CW_MEMWRITE] = is_stype;
    raw[CW_MEM2REG]  = is_lw;
    raw[CW_BRANCH]   = is_branch;
    raw[CW_JUMP]     = is_jump;
  end

  // A multi-flag word must never reach memory or the register file.
  always_comb begin
    illegal = id_valid & multi;
    bubble  = ~id_valid | multi;
    cw      = bubble ? CW_BUBBLE : raw;
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - pipelined control decoder with bubbles, freeze and load-use stall
// Optional: HAZARD_DETECT_EN enables load-use detection and the stall counter.
module ctrl_pipe_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic                        is_stype,
  input  logic                        is_rtype,
  input  logic                        is_itype,
  input  logic                        is_lw,
  input  logic                        is_jump,
  input  logic                        is_branch,
  input  logic [REG_ADDR_W-1:0]       id_rs1,
  input  logic [REG_ADDR_W-1:0]       id_rs2,
  input  logic [REG_ADDR_W-1:0]       id_rd,
  input  logic                        stall_in,
  input  logic                        flush,
  output logic [DEPTH*CW_W-1:0]       stage_ctrl,
  output logic [DEPTH*REG_ADDR_W-1:0] stage_rd,
  output logic                        hazard_stall,
  output logic                        illegal_op,
  output logic [PERF_W-1:0]           stall_cnt
);

  ctrl_word_t            dec_cw;
  logic                  dec_bubble;
  logic                  dec_illegal;
  logic [REG_ADDR_W-1:0] dec_rd;

  ctrl_word_t            cw_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];

  ctrl_decode #(.REG_ADDR_W(REG_ADDR_W)) u_decode (
    .id_valid  (id_valid),
    .is_stype  (is_stype),
    .is_rtype  (is_rtype),
    .is_itype  (is_itype),
    .is_lw     (is_lw),
    .is_jump   (is_jump),
    .is_branch (is_branch),
    .id_rd     (id_rd),
    .cw        (dec_cw),
    .bubble    (dec_bubble),
    .illegal   (dec_illegal)
  );

  assign dec_rd = dec_bubble ? '0 : id_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_q[0] <= CW_BUBBLE;
      rd_q[0] <= '0;
    end else if (!stall_in) begin
      if (flush || hazard_stall) begin
        cw_q[0] <= CW_BUBBLE;
        rd_q[0] <= '0;
      end else begin
        cw_q[0] <= dec_cw;
        rd_q[0] <= dec_rd;
      end
    end
  end

  for (genvar k = 1; k < DEPTH; k++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cw_q[k] <= CW_BUBBLE;
        rd_q[k] <= '0;
      end else if (!stall_in) begin
        cw_q[k] <= cw_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_pack
    assign stage_ctrl[k*CW_W +: CW_W]             = cw_q[k];
    assign stage_rd[k*REG_ADDR_W +: REG_ADDR_W]   = rd_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= dec_illegal & ~stall_in;
    end
  end

`ifdef HAZARD_DETECT_EN
  // Only stage 0 can hold a load whose data is not yet forwardable.
  always_comb begin
    hazard_stall = cw_q[0][CW_MEMREAD] & (rd_q[0] != '0) & id_valid &
                   (((rd_q[0] == id_rs1) & ~is_jump) |
                    ((rd_q[0] == id_rs2) & (is_rtype | is_stype | is_branch)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard_stall && !stall_in && (stall_cnt != {PERF_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_src;
  assign unused_src   = ^{id_rs1, id_rs2};
  assign hazard_stall = 1'b0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb/tb_ctrl_pipe_unit.sv - directed self-checking bench for ctrl_pipe_unit
module tb_ctrl_pipe_unit;

`ifdef HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  localparam logic [5:0] F_S  = 6'b000001;
  localparam logic [5:0] F_R  = 6'b000010;
  localparam logic [5:0] F_I  = 6'b000100;
  localparam logic [5:0] F_LW = 6'b001000;
  localparam logic [5:0] F_J  = 6'b010000;

  localparam logic [6:0] CW_R   = 7'b0000001;
  localparam logic [6:0] CW_I   = 7'b0000011;
  localparam logic [6:0] CW_LW  = 7'b0010111;
  localparam logic [6:0] CW_LW0 = 7'b0010110;
  localparam logic [6:0] CW_SW  = 7'b0001010;
  localparam logic [6:0] CW_JAL = 7'b1000011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, is_stype, is_rtype, is_itype, is_lw, is_jump, is_branch;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall_in, flush;
  logic [20:0] stage_ctrl;
  logic [14:0] stage_rd;
  logic        hazard_stall, illegal_op;
  logic [3:0]  stall_cnt;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.DEPTH(3), .REG_ADDR_W(5), .PERF_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .is_stype     (is_stype),
    .is_rtype     (is_rtype),
    .is_itype     (is_itype),
    .is_lw        (is_lw),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .stall_in     (stall_in),
    .flush        (flush),
    .stage_ctrl   (stage_ctrl),
    .stage_rd     (stage_rd),
    .hazard_stall (hazard_stall),
    .illegal_op   (illegal_op),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [5:0] f,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid  = v;
    is_stype  = f[0];
    is_rtype  = f[1];
    is_itype  = f[2];
    is_lw     = f[3];
    is_jump   = f[4];
    is_branch = f[5];
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
    repeat (3) step();
  endtask

  initial begin
    // Reset with every input high.
    rst_n = 1'b0;
    set_id(1'b1, 6'b111111, 5'd31, 5'd31, 5'd31);
    stall_in = 1'b1;
    flush    = 1'b1;
    #12;
    chk("rst_ctrl", 32'(stage_ctrl), 32'h0);
    chk("rst_rd", 32'(stage_rd), 32'h0);
    chk("rst_illegal", 32'(illegal_op), 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_hazard", 32'(hazard_stall), 32'h0);
    set_id(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
    stall_in = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_ctrl", 32'(stage_ctrl), 32'h0);
    end

    // Single R-type walks through all three stages.
    set_id(1'b1, F_R, 5'd1, 5'd2, 5'd5);
    step();
    chk("r_s0_ctrl", 32'(stage_ctrl), 32'({14'b0, CW_R}));
    chk("r_s0_rd", 32'(stage_rd), 32'({10'b0, 5'd5}));
    set_id(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
    step();
    chk("r_s1_ctrl", 32'(stage_ctrl), 32'({7'b0, CW_R, 7'b0}));
    step();
    chk("r_s2_ctrl", 32'(stage_ctrl), 32'({CW_R, 14'b0}));
    chk("r_s2_rd", 32'(stage_rd), 32'({5'd5, 10'b0}));
    step();
    chk("r_out_ctrl", 32'(stage_ctrl), 32'h0);

    // lw rd=3 then add rs1=3.
    set_id(1'b1, F_LW, 5'd0, 5'd0, 5'd3);
    step();
    chk("lw_s0_ctrl", 32'(stage_ctrl[6:0]), 32'(CW_LW));
    set_id(1'b1, F_R, 5'd3, 5'd4, 5'd6);
    #1;
    chk("lu_hazard", 32'(hazard_stall), 32'(HZ));
    step();
    chk("lu_s0_ctrl", 32'(stage_ctrl[6:0]), HZ ? 32'h0 : 32'(CW_R));
    chk("lu_s1_ctrl", 32'(stage_ctrl[13:7]), 32'(CW_LW));
    chk("lu_cnt", 32'(stall_cnt), HZ ? 32'd1 : 32'd0);
    chk("lu_hazard_clr", 32'(hazard_stall), 32'h0);
    step();
    chk("lu_add_ctrl", 32'(stage_ctrl[6:0]), 32'(CW_R));
    chk("lu_add_rd", 32'(stage_rd[4:0]), 32'd6);

    // lw rd=0 never stalls.
    set_id(1'b1, F_LW, 5'd0, 5'd0, 5'd0);
    step();
    chk("lw0_ctrl", 32'(stage_ctrl[6:0]), 32'(CW_LW0));
    set_id(1'b1, F_R, 5'd0, 5'd0, 5'd6);
    #1;
    chk("lw0_hazard", 32'(hazard_stall), 32'h0);

    // sw rs2=3 after lw rd=3.
    set_id(1'b1, F_LW, 5'd0, 5'd0, 5'd3);
    step();
    set_id(1'b1, F_S, 5'd1, 5'd3, 5'd0);
    #1;
    chk("sw_hazard", 32'(hazard_stall), 32'(HZ));
    step();
    chk("sw_cnt", 32'(stall_cnt), HZ ? 32'd2 : 32'd0);
    chk("sw_s0_ctrl", 32'(stage_ctrl[6:0]), HZ ? 32'h0 : 32'(CW_SW));

    // jal with rs1=rs2=3 after lw rd=3: no stall.
    set_id(1'b1, F_LW, 5'd0, 5'd0, 5'd3);
    step();
    set_id(1'b1, F_J, 5'd3, 5'd3, 5'd1);
    #1;
    chk("jal_hazard", 32'(hazard_stall), 32'h0);
    step();
    chk("jal_s0_ctrl", 32'(stage_ctrl[6:0]), 32'(CW_JAL));
    chk("jal_cnt", 32'(stall_cnt), HZ ? 32'd2 : 32'd0);

    // Fill pipeline: lw rd3, I rd2, R rd7, then freeze.
    drain();
    set_id(1'b1, F_LW, 5'd0, 5'd0, 5'd3);
    step();
    set_id(1'b1, F_I, 5'd1, 5'd0, 5'd2);
    step();
    set_id(1'b1, F_R, 5'd1, 5'd2, 5'd7);
    step();
    chk("full_ctrl", 32'(stage_ctrl), 32'({CW_LW, CW_I, CW_R}));
    chk("full_rd", 32'(stage_rd), 32'({5'd3, 5'd2, 5'd7}));
    set_id(1'b1, F_S, 5'd1, 5'd3, 5'd0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 2);
      step();
      chk("frz_ctrl", 32'(stage_ctrl), 32'({CW_LW, CW_I, CW_R}));
      chk("frz_rd", 32'(stage_rd), 32'({5'd3, 5'd2, 5'd7}));
      chk("frz_illegal", 32'(illegal_op), 32'h0);
    end
    chk("frz_cnt", 32'(stall_cnt), HZ ? 32'd2 : 32'd0);

    // Flush with sw in ID.
    stall_in = 1'b0;
    flush    = 1'b1;
    step();
    chk("fl_ctrl", 32'(stage_ctrl), 32'({CW_I, CW_R, 7'b0}));
    chk("fl_rd", 32'(stage_rd), 32'({5'd2, 5'd7, 5'd0}));
    flush = 1'b0;
    set_id(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
    step();
    chk("fl_ctrl2", 32'(stage_ctrl), 32'({CW_R, 14'b0}));
    step();
    chk("fl_ctrl3", 32'(stage_ctrl), 32'h0);

    // Two type flags together.
    set_id(1'b1, F_LW | F_R, 5'd0, 5'd0, 5'd4);
    step();
    chk("ill_pulse", 32'(illegal_op), 32'h1);
    chk("ill_ctrl", 32'(stage_ctrl[6:0]), 32'h0);
    chk("ill_rd", 32'(stage_rd[4:0]), 32'h0);
    set_id(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
    step();
    chk("ill_clr", 32'(illegal_op), 32'h0);

    // Repeated load-use stalls until the counter saturates.
    for (int i = 0; i < 18; i++) begin
      set_id(1'b1, F_LW, 5'd0, 5'd0, 5'd3);
      step();
      set_id(1'b1, F_R, 5'd3, 5'd4, 5'd6);
      #1;
      chk("sat_hazard", 32'(hazard_stall), 32'(HZ));
      step();
      chk("sat_cnt", 32'(stall_cnt), HZ ? ((3 + i) > 15 ? 32'd15 : 32'(3 + i)) : 32'd0);
    end

    // Asynchronous reset mid-cycle.
    set_id(1'b1, F_R, 5'd1, 5'd2, 5'd5);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 32'(stage_ctrl), 32'h0);
    chk("arst_rd", 32'(stage_rd), 32'h0);
    chk("arst_cnt", 32'(stall_cnt), 32'h0);
    chk("arst_illegal", 32'(illegal_op), 32'h0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
